// File: rtl/sqrt_lut_pkg.sv
// Shared constants and helpers for the pipelined 16-bit integer square root.
// Exports:
//   IN_W, OUT_W   operand / result widths
//   SQRT_LATENCY  cycles from operand presentation to result
//   isqrt8()      floor(sqrt(v)) of an 8-bit value, used as the coarse ROM
package sqrt_lut_pkg;

    localparam int unsigned IN_W         = 16;
    localparam int unsigned OUT_W        = 8;
    localparam int unsigned SQRT_LATENCY = 5;

    // Constant table: each range is [n*n, (n+1)*(n+1)-1] mapped to n.
    function automatic logic [3:0] isqrt8(input logic [7:0] v);
        logic [3:0] r;
        case (v) inside
            [8'd0   : 8'd0  ]: r = 4'd0;
            [8'd1   : 8'd3  ]: r = 4'd1;
            [8'd4   : 8'd8  ]: r = 4'd2;
            [8'd9   : 8'd15 ]: r = 4'd3;
            [8'd16  : 8'd24 ]: r = 4'd4;
            [8'd25  : 8'd35 ]: r = 4'd5;
            [8'd36  : 8'd48 ]: r = 4'd6;
            [8'd49  : 8'd63 ]: r = 4'd7;
            [8'd64  : 8'd80 ]: r = 4'd8;
            [8'd81  : 8'd99 ]: r = 4'd9;
            [8'd100 : 8'd120]: r = 4'd10;
            [8'd121 : 8'd143]: r = 4'd11;
            [8'd144 : 8'd168]: r = 4'd12;
            [8'd169 : 8'd195]: r = 4'd13;
            [8'd196 : 8'd224]: r = 4'd14;
            default:           r = 4'd15;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sqrt_lut_step.sv
// One refinement stage of the square-root pipeline: tries setting bit BIT of
// the partial root and keeps it if the trial square does not exceed x.
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   x_i / x_o        operand, carried forward one stage
//   r_i / r_o        partial root in / refined root out (registered)
//   val_i / val_o    valid flag, delayed one stage
module sqrt_lut_step #(
    parameter int unsigned BIT = 0
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [sqrt_lut_pkg::IN_W-1:0]      x_i,
    input  logic [sqrt_lut_pkg::OUT_W-1:0]     r_i,
    input  logic                               val_i,
    output logic [sqrt_lut_pkg::IN_W-1:0]      x_o,
    output logic [sqrt_lut_pkg::OUT_W-1:0]     r_o,
    output logic                               val_o
);
    import sqrt_lut_pkg::*;

    logic [OUT_W-1:0] t;
    logic [IN_W-1:0]  t_sq;
    logic [OUT_W-1:0] r_d;
    logic [IN_W-1:0]  x_q;
    logic [OUT_W-1:0] r_q;
    logic             val_q;

    // 8x8 product of the trial root never exceeds 255*255, so 16 bits suffice.
    always_comb begin
        t    = r_i | OUT_W'(1 << BIT);
        t_sq = IN_W'(t) * IN_W'(t);
        r_d  = (t_sq <= x_i) ? t : r_i;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q   <= '0;
            r_q   <= '0;
            val_q <= 1'b0;
        end else begin
            x_q   <= x_i;
            r_q   <= r_d;
            val_q <= val_i;
        end
    end

    assign x_o   = x_q;
    assign r_o   = r_q;
    assign val_o = val_q;

endmodule

// File: rtl/sqrt_lut.sv
// Fully pipelined floor(sqrt(x)) for a 16-bit unsigned operand, one result
// per clock, fixed latency of SQRT_LATENCY cycles, no back-pressure.
// Stage 1 looks up the top four root bits from the operand's high byte;
// four refinement stages then resolve bits 3..0.
// Ports:
//   clk, rst_n    clock, synchronous active-low reset (clears all stages)
//   sqrt_lut_i    operand x
//   val_i         operand valid
//   sqrt_lut_o    floor(sqrt(x)), registered
//   val_o         result valid, registered
module sqrt_lut #(
    parameter int unsigned IN_W  = sqrt_lut_pkg::IN_W,  // only 16 supported
    parameter int unsigned OUT_W = sqrt_lut_pkg::OUT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  sqrt_lut_i,
    input  logic             val_i,
    output logic [OUT_W-1:0] sqrt_lut_o,
    output logic             val_o
);
    import sqrt_lut_pkg::isqrt8;

    localparam int unsigned NumSteps = 4;

    // Index 0 is the coarse stage output; index NumSteps is the final stage.
    logic [IN_W-1:0]  x_s   [NumSteps+1];
    logic [OUT_W-1:0] r_s   [NumSteps+1];
    logic             val_s [NumSteps+1];

    logic [3:0]       coarse;
    logic [IN_W-1:0]  x_q;
    logic [OUT_W-1:0] r_q;
    logic             val_q;

    // isqrt(x) >> 4 == isqrt(x >> 8), so the high byte fixes the top nibble.
    always_comb begin
        coarse = isqrt8(sqrt_lut_i[IN_W-1:IN_W-8]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q   <= '0;
            r_q   <= '0;
            val_q <= 1'b0;
        end else begin
            x_q   <= sqrt_lut_i;
            r_q   <= {coarse, 4'b0000};
            val_q <= val_i;
        end
    end

    assign x_s[0]   = x_q;
    assign r_s[0]   = r_q;
    assign val_s[0] = val_q;

    for (genvar i = 0; i < NumSteps; i++) begin : g_step
        sqrt_lut_step #(
            .BIT(NumSteps - 1 - i)
        ) u_step (
            .clk   (clk),
            .rst_n (rst_n),
            .x_i   (x_s[i]),
            .r_i   (r_s[i]),
            .val_i (val_s[i]),
            .x_o   (x_s[i+1]),
            .r_o   (r_s[i+1]),
            .val_o (val_s[i+1])
        );
    end

    assign sqrt_lut_o = r_s[NumSteps];
    assign val_o      = val_s[NumSteps];

    // The operand is not needed past the last refinement stage.
    logic unused_x_last;
    assign unused_x_last = ^x_s[NumSteps];

endmodule

// File: tb/tb_sqrt_lut.sv
// Self-checking bench for sqrt_lut: directed steps drive operands, expected
// roots are queued with their issue cycle and checked as val_o pulses appear.
module tb_sqrt_lut;
    import sqrt_lut_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [15:0] sqrt_lut_i;
    logic        val_i;
    logic [7:0]  sqrt_lut_o;
    logic        val_o;

    typedef struct {
        logic [15:0] x;
        logic [7:0]  exp;
        int          stamp;
    } item_t;

    item_t q[$];
    int    cyc     = 0;
    int    n_assert = 0;
    int    n_fail   = 0;

    sqrt_lut #(
        .IN_W (16),
        .OUT_W(8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sqrt_lut_i(sqrt_lut_i),
        .val_i     (val_i),
        .sqrt_lut_o(sqrt_lut_o),
        .val_o     (val_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Reference floor sqrt computed via real arithmetic, then corrected.
    function automatic logic [7:0] isqrt_model(input logic [15:0] x);
        int r;
        r = int'($floor($sqrt(real'(x))));
        while (r * r > int'(x)) r--;
        while ((r + 1) * (r + 1) <= int'(x)) r++;
        return r[7:0];
    endfunction

    // Drive one cycle of input; valid operands are queued with their issue cycle.
    task automatic drive(input logic v, input logic [15:0] x, input logic [7:0] exp);
        item_t it;
        @(posedge clk);
        #1;
        val_i      = v;
        sqrt_lut_i = x;
        if (v && rst_n) begin
            it.x     = x;
            it.exp   = exp;
            it.stamp = cyc;
            q.push_back(it);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 16'h0000, 8'h00);
    endtask

    task automatic drive_m(input logic [15:0] x);
        drive(1'b1, x, isqrt_model(x));
    endtask

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        item_t it;
        if (val_o === 1'b1) begin
            n_assert++;
            assert (q.size() != 0) else begin
                n_fail++;
                $error("FAIL spurious_val: val_o=%b with %0d results expected", val_o, q.size());
            end
            if (q.size() != 0) begin
                it = q.pop_front();
                n_assert++;
                assert (sqrt_lut_o === it.exp) else begin
                    n_fail++;
                    $error("FAIL data x=%h: observed %h expected %h", it.x, sqrt_lut_o, it.exp);
                end
                n_assert++;
                assert ((cyc - it.stamp) === 5) else begin
                    n_fail++;
                    $error("FAIL latency x=%h: observed %0d expected %0d",
                           it.x, cyc - it.stamp, 5);
                end
            end
        end
    end

    initial begin
        logic [15:0] singles_x [7];
        logic [7:0]  singles_e [7];
        logic [15:0] x;
        logic [15:0] gap_x [6];
        logic        gap_v [6];
        logic [7:0]  gap_e [6];

        singles_x = '{16'h0000, 16'h0001, 16'h00FF, 16'h0100, 16'h3FFF, 16'h4000, 16'hFFFF};
        singles_e = '{8'h00,    8'h01,    8'h0F,    8'h10,    8'h7F,    8'h80,    8'hFF};
        gap_v     = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        gap_x     = '{16'h0010, 16'h0000, 16'h0000, 16'h0024, 16'h0031, 16'h0000};
        gap_e     = '{8'h04, 8'h00, 8'h00, 8'h06, 8'h07, 8'h00};

        rst_n      = 1'b0;
        val_i      = 1'b0;
        sqrt_lut_i = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_assert++;
        assert (sqrt_lut_o === 8'h00) else begin
            n_fail++;
            $error("FAIL reset_data: observed %h expected %h", sqrt_lut_o, 8'h00);
        end
        n_assert++;
        assert (val_o === 1'b0) else begin
            n_fail++;
            $error("FAIL reset_val: observed %b expected %b", val_o, 1'b0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Isolated operands with fixed expected roots.
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, singles_x[i], singles_e[i]);
            idle(7);
        end

        // Gapped valid pattern.
        for (int i = 0; i < 6; i++) drive(gap_v[i], gap_x[i], gap_e[i]);
        idle(8);

        // Back-to-back random stream, then exhaustive sweep.
        for (int i = 0; i < 1024; i++) drive_m(16'($urandom_range(0, 65535)));
        for (int i = 0; i < 65536; i++) drive_m(16'(i));
        idle(8);

        // Square boundaries: n*n -> n and n*n-1 -> n-1.
        for (int n = 1; n < 256; n++) begin
            x = 16'(n * n);
            drive(1'b1, x, 8'(n));
            drive(1'b1, x - 16'd1, 8'(n - 1));
        end
        idle(8);

        // Reset with three operands in flight; operand during reset is dropped.
        drive(1'b1, 16'h0400, 8'h20);
        drive(1'b1, 16'h0900, 8'h30);
        drive(1'b1, 16'h1000, 8'h40);
        @(posedge clk);
        #1;
        rst_n      = 1'b0;
        val_i      = 1'b1;
        sqrt_lut_i = 16'h2400;
        q.delete();
        @(negedge clk);
        n_assert++;
        assert (sqrt_lut_o === 8'h00) else begin
            n_fail++;
            $error("FAIL midreset_data: observed %h expected %h", sqrt_lut_o, 8'h00);
        end
        n_assert++;
        assert (val_o === 1'b0) else begin
            n_fail++;
            $error("FAIL midreset_val: observed %b expected %b", val_o, 1'b0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        val_i = 1'b0;
        drive(1'b1, 16'h0051, 8'h09);
        idle(10);

        n_assert++;
        assert (q.size() === 0) else begin
            n_fail++;
            $error("FAIL drain: observed %0d pending results expected %0d", q.size(), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
